vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port video RAM between the VGA scanout path and CPU load/store requests. Prefetches sequential pixel words into a small FIFO ahead of the display and services CPU accesses in the gaps. Sits between the VGA timing generator (display side), the CPU memory-mapped graphics port, and the video SRAM controller.

## Interface
Parameters:
- AW, 19, address width (words).
- DW, 8, pixel/data word width.
- DEPTH, 16, prefetch FIFO depth; power of two, ≥4.
- LOW_WM, 4, low-watermark level below which display wins; 1 ≤ LOW_WM < DEPTH.
- FRAME_WORDS, 307200, words fetched per frame (640×480).

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset; synchronous, active-high.
- frame_start, in, 1, one-cycle pulse before first visible pixel: flush FIFO, restart fetch at address 0.
- pix_pop, in, 1, display consumes head pixel this cycle.
- pix_data, out, DW, FIFO head word.
- pix_valid, out, 1, FIFO non-empty.
- underflow, out, 1, sticky: pop seen while empty.
- cpu_req, in, 1, CPU access request; held until cpu_ack.
- cpu_we, in, 1, 1 = write, 0 = read.
- cpu_addr, in, AW, CPU word address.
- cpu_wdata, in, DW, write data.
- cpu_ack, out, 1, one-cycle completion pulse.
- cpu_rdata, out, DW, read data, valid while cpu_ack=1.
- mem_en, out, 1, RAM access enable.
- mem_we, out, 1, RAM write enable.
- mem_addr, out, AW, RAM address.
- mem_wdata, out, DW, RAM write data.
- mem_rdata, in, DW, RAM read data, valid one cycle after a read issue.

## Operation
- State: FIFO (DEPTH×DW, count 0..DEPTH), fetch_addr (AW), fetch_done, disp_inflight (1 bit), cpu_inflight (1 bit), FSM {RUN, CPU_WAIT}.
- level = FIFO count + disp_inflight. Display read eligible iff !fetch_done and level < DEPTH (level uses count after this cycle's pop).
- Grant each cycle, combinational, priority order:
  1. display if eligible and level < LOW_WM;
  2. CPU if cpu_req and FSM = RUN;
  3. display if eligible;
  4. none (mem_en=0).
- Display grant: mem_en=1, mem_we=0, mem_addr=fetch_addr; fetch_addr+1; on issuing FRAME_WORDS-1 set fetch_done (no further fetch until frame_start).
- CPU grant: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata; FSM→CPU_WAIT; next cycle cpu_ack=1 (cpu_rdata=mem_rdata for reads, 0 for writes), FSM→RUN. CPU_WAIT blocks re-grant of the same held request.
- Returning display data pushed into FIFO at the cycle after issue. Push and pop in the same cycle leave count unchanged.
- pix_pop while empty: no state change except underflow←1; pix_data holds its last value.
- frame_start: FIFO count←0, fetch_addr←0, fetch_done←0, underflow←0; a display read in flight is discarded on return. No display grant in the frame_start cycle. CPU access in flight completes normally.
- Reset: all outputs 0, FIFO empty, fetch_addr 0, fetch_done 0, inflight flags 0, FSM RUN. mem_en forced 0 while rst=1.

## Timing
- Display read latency: issue cycle t, FIFO push at end of t+1, pix_valid/pix_data updated at t+2.
- CPU latency: cpu_req at t with grant → cpu_ack at t+1; max throughput one CPU access per 2 cycles.
- pix_data is registered FIFO head; a pop at t exposes the next word at t+1.
- CPU starvation bound: with at most one pop per 2 cycles and level ≥ LOW_WM, a pending CPU request is granted within 2 cycles.

## Test plan
- Reset prefill: rst 1→0, no CPU, RAM holds mem[i]=i → mem_addr 0..15 on cycles 0..15, pix_valid at cycle 2 with pix_data=0, mem_en=0 from cycle 16, count=16.
- CPU write with full FIFO: cpu_req=1, cpu_we=1, addr=0x100, data=0xA5 → same-cycle mem_we=1, mem_addr=0x100, mem_wdata=0xA5; cpu_ack next cycle; no second grant.
- Watermark priority: level=3, cpu_req pending → display read granted first; CPU granted once level reaches 4.
- Flush: frame_start while a display read of address 9 is in flight → that data is dropped, fetch restarts at 0, first pix_data after refill = mem[0].
- Underflow: pix_pop with FIFO empty → underflow=1, stays 1 through further pops, cleared by frame_start.
- End of frame (FRAME_WORDS=20): fetch stops after address 19, mem_en stays 0 with free FIFO space until frame_start; CPU reads still served with cpu_rdata=mem[cpu_addr].

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares a single-port video RAM between the VGA scanout path and
//            CPU load/store requests. Sequential pixel words are prefetched
//            into a small FIFO ahead of the display; CPU accesses are served
//            in the gaps, except when the FIFO drops below a low watermark.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            frame_start                   - flush FIFO, restart fetch at word 0
//            pix_pop / pix_data / pix_valid - display-side FIFO head interface
//            underflow                     - sticky pop-while-empty flag
//            cpu_req/we/addr/wdata         - CPU request (held until cpu_ack)
//            cpu_ack / cpu_rdata           - one-cycle completion pulse + data
//            mem_en/we/addr/wdata/rdata    - SRAM controller port (1-cycle read)
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int AW          = 19,
    parameter int DW          = 8,
    parameter int DEPTH       = 16,
    parameter int LOW_WM      = 4,
    parameter int FRAME_WORDS = 307200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_pop,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          underflow,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int              c_PW        = $clog2(DEPTH);
    localparam int              c_CW        = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_LOW_WM    = c_CW'(LOW_WM);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
    localparam logic [AW-1:0]   c_LAST_ADDR = AW'(FRAME_WORDS - 1);

    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_CPU_WAIT = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0]   r_fifo [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [DW-1:0]   r_pix_data;
    logic            r_underflow;
    logic [AW-1:0]   r_fetch_addr;
    logic            r_fetch_done;
    logic            r_disp_inflight;
    logic            r_cpu_we;
    logic [0:0]      r_state;

    logic [0:0]      w_state_next;
    logic            w_pop_ok;
    logic            w_push;
    logic [c_CW-1:0] w_count_after_pop;
    logic [c_CW-1:0] w_level;
    logic            w_disp_elig;
    logic            w_disp_urgent;
    logic            w_cpu_ok;
    logic            w_grant_cpu;
    logic            w_grant_disp;
    logic [c_PW-1:0] w_rd_ptr_inc;
    logic [DW-1:0]   w_head_next;

    // ------------------------------------------------------------------------
    // Occupancy and grant
    // ------------------------------------------------------------------------
    // A pop against an empty FIFO has no effect on occupancy.
    assign w_pop_ok          = pix_pop && (r_count != '0);
    // Data returning for a read issued before a flush belongs to the old frame.
    assign w_push            = r_disp_inflight && !frame_start;
    assign w_count_after_pop = r_count - c_CW'(w_pop_ok);
    // The in-flight read already owns a FIFO slot.
    assign w_level           = w_count_after_pop + c_CW'(r_disp_inflight);

    assign w_disp_elig   = !rst && !frame_start && !r_fetch_done && (w_level < c_DEPTH);
    assign w_disp_urgent = w_disp_elig && (w_level < c_LOW_WM);
    assign w_cpu_ok      = !rst && cpu_req && (r_state == c_ST_RUN);

    // Display below the watermark beats the CPU; otherwise the CPU wins and
    // the display takes any cycle the CPU leaves idle.
    assign w_grant_cpu  = w_cpu_ok && !w_disp_urgent;
    assign w_grant_disp = w_disp_elig && !w_grant_cpu;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant_cpu) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_grant_disp) begin
            mem_en    = 1'b1;
            mem_addr  = r_fetch_addr;
        end
    end

    // ------------------------------------------------------------------------
    // CPU handshake FSM: CPU_WAIT spans the RAM read latency and keeps the
    // still-held request from being granted a second time.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_RUN;
            r_cpu_we <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_cpu) begin
                r_cpu_we <= cpu_we;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        cpu_ack      = 1'b0;
        cpu_rdata    = '0;
        case (r_state)
            c_ST_RUN: begin
                if (w_grant_cpu) begin
                    w_state_next = c_ST_CPU_WAIT;
                end
            end
            c_ST_CPU_WAIT: begin
                cpu_ack      = 1'b1;
                cpu_rdata    = r_cpu_we ? '0 : mem_rdata;
                w_state_next = c_ST_RUN;
            end
            default: begin
                w_state_next = c_ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Prefetch FIFO with a registered head word
    // ------------------------------------------------------------------------
    assign w_rd_ptr_inc = r_rd_ptr + c_PW'(1);

    // r_pix_data always mirrors r_fifo[r_rd_ptr] while the FIFO is non-empty,
    // and otherwise keeps the last word shown.
    always_comb begin
        w_head_next = r_pix_data;
        if (w_pop_ok) begin
            if (r_count > c_ONE) begin
                w_head_next = r_fifo[w_rd_ptr_inc];
            end else if (w_push) begin
                w_head_next = mem_rdata;
            end
        end else if ((r_count == '0) && w_push) begin
            w_head_next = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo[r_wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_pix_data      <= '0;
            r_underflow     <= 1'b0;
            r_fetch_addr    <= '0;
            r_fetch_done    <= 1'b0;
            r_disp_inflight <= 1'b0;
        end else begin
            r_disp_inflight <= w_grant_disp;
            if (frame_start) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
                r_underflow  <= 1'b0;
                r_fetch_addr <= '0;
                r_fetch_done <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PW'(1);
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
                r_count    <= w_count_after_pop + c_CW'(w_push);
                r_pix_data <= w_head_next;
                if (pix_pop && (r_count == '0)) begin
                    r_underflow <= 1'b1;
                end
                if (w_grant_disp) begin
                    r_fetch_addr <= r_fetch_addr + AW'(1);
                    if (r_fetch_addr == c_LAST_ADDR) begin
                        r_fetch_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign pix_data  = r_pix_data;
    assign pix_valid = (r_count != '0);
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Directed self-checking bench for vram_arbiter with a small
//            synchronous RAM model holding mem[i] = i (low 8 bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          pix_pop;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          underflow;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    vram_arbiter #(
        .AW(AW), .DW(DW), .DEPTH(16), .LOW_WM(4), .FRAME_WORDS(20)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_pop(pix_pop),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, contents loaded while in reset.
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) ram[i] <= i[DW-1:0];
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    typedef struct {
        logic          fs, pop, req, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          en, mwe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        logic          ack;
        logic [DW-1:0] rdata;
        logic          pv;
        logic [DW-1:0] pd;
        logic          uf;
    } vec_t;

    vec_t vecs [33];

    function automatic vec_t mk(
        input logic fs, input logic pop, input logic req, input logic we,
        input logic [AW-1:0] addr, input logic [DW-1:0] wd,
        input logic en, input logic mwe, input logic [AW-1:0] maddr,
        input logic [DW-1:0] mwd, input logic ack, input logic [DW-1:0] rdata,
        input logic pv, input logic [DW-1:0] pd, input logic uf);
        vec_t v;
        v.fs = fs; v.pop = pop; v.req = req; v.we = we; v.addr = addr; v.wd = wd;
        v.en = en; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd; v.ack = ack;
        v.rdata = rdata; v.pv = pv; v.pd = pd; v.uf = uf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    initial begin
        //               fs pop req we  addr     wd      en mwe maddr    mwd     ack rdata  pv pd     uf
        // Full FIFO: CPU write then read-back of 0x100
        vecs[0]  = mk(0, 0, 1, 1, 19'h100, 8'hA5,  1, 1, 19'h100, 8'hA5, 0, 8'h00, 1, 8'h00, 0);
        vecs[1]  = mk(0, 0, 1, 1, 19'h100, 8'hA5,  0, 0, 19'h0,   8'h00, 1, 8'h00, 1, 8'h00, 0);
        vecs[2]  = mk(0, 0, 1, 0, 19'h100, 8'h00,  1, 0, 19'h100, 8'h00, 0, 8'h00, 1, 8'h00, 0);
        vecs[3]  = mk(0, 0, 1, 0, 19'h100, 8'h00,  0, 0, 19'h0,   8'h00, 1, 8'hA5, 1, 8'h00, 0);
        vecs[4]  = mk(0, 0, 0, 0, 19'h0,   8'h00,  0, 0, 19'h0,   8'h00, 0, 8'h00, 1, 8'h00, 0);
        // Pops refill 16..19, then end of frame stops fetching
        vecs[5]  = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd16,  8'h00, 0, 8'h00, 1, 8'h00, 0);
        vecs[6]  = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd17,  8'h00, 0, 8'h00, 1, 8'h01, 0);
        vecs[7]  = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd18,  8'h00, 0, 8'h00, 1, 8'h02, 0);
        vecs[8]  = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd19,  8'h00, 0, 8'h00, 1, 8'h03, 0);
        vecs[9]  = mk(0, 1, 0, 0, 19'h0,   8'h00,  0, 0, 19'h0,   8'h00, 0, 8'h00, 1, 8'h04, 0);
        vecs[10] = mk(0, 0, 1, 0, 19'h5,   8'h00,  1, 0, 19'h5,   8'h00, 0, 8'h00, 1, 8'h05, 0);
        vecs[11] = mk(0, 0, 1, 0, 19'h5,   8'h00,  0, 0, 19'h0,   8'h00, 1, 8'h05, 1, 8'h05, 0);
        vecs[12] = mk(0, 0, 0, 0, 19'h0,   8'h00,  0, 0, 19'h0,   8'h00, 0, 8'h00, 1, 8'h05, 0);
        // frame_start, refill with watermark contest at level 3 / 4
        vecs[13] = mk(1, 0, 0, 0, 19'h0,   8'h00,  0, 0, 19'h0,   8'h00, 0, 8'h00, 1, 8'h05, 0);
        vecs[14] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd0,   8'h00, 0, 8'h00, 0, 8'h05, 0);
        vecs[15] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd1,   8'h00, 0, 8'h00, 0, 8'h05, 0);
        vecs[16] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd2,   8'h00, 0, 8'h00, 1, 8'h00, 0);
        vecs[17] = mk(0, 0, 1, 1, 19'h200, 8'h3C,  1, 0, 19'd3,   8'h00, 0, 8'h00, 1, 8'h00, 0);
        vecs[18] = mk(0, 0, 1, 1, 19'h200, 8'h3C,  1, 1, 19'h200, 8'h3C, 0, 8'h00, 1, 8'h00, 0);
        vecs[19] = mk(0, 0, 1, 1, 19'h200, 8'h3C,  1, 0, 19'd4,   8'h00, 1, 8'h00, 1, 8'h00, 0);
        vecs[20] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd5,   8'h00, 0, 8'h00, 1, 8'h00, 0);
        vecs[21] = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd6,   8'h00, 0, 8'h00, 1, 8'h00, 0);
        vecs[22] = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd7,   8'h00, 0, 8'h00, 1, 8'h01, 0);
        vecs[23] = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd8,   8'h00, 0, 8'h00, 1, 8'h02, 0);
        vecs[24] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd9,   8'h00, 0, 8'h00, 1, 8'h03, 0);
        // Flush with read of address 9 in flight; underflow on empty pops
        vecs[25] = mk(1, 0, 0, 0, 19'h0,   8'h00,  0, 0, 19'h0,   8'h00, 0, 8'h00, 1, 8'h03, 0);
        vecs[26] = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd0,   8'h00, 0, 8'h00, 0, 8'h03, 0);
        vecs[27] = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd1,   8'h00, 0, 8'h00, 0, 8'h03, 1);
        vecs[28] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd2,   8'h00, 0, 8'h00, 1, 8'h00, 1);
        vecs[29] = mk(0, 1, 0, 0, 19'h0,   8'h00,  1, 0, 19'd3,   8'h00, 0, 8'h00, 1, 8'h00, 1);
        vecs[30] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd4,   8'h00, 0, 8'h00, 1, 8'h01, 1);
        vecs[31] = mk(1, 0, 0, 0, 19'h0,   8'h00,  0, 0, 19'h0,   8'h00, 0, 8'h00, 1, 8'h01, 1);
        vecs[32] = mk(0, 0, 0, 0, 19'h0,   8'h00,  1, 0, 19'd0,   8'h00, 0, 8'h00, 0, 8'h01, 0);

        rst = 1'b1; frame_start = 1'b0; pix_pop = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset state, with a CPU request asserted to show mem_en is held low.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h1; cpu_wdata = 8'h11;
        #1;
        chk("reset mem_en",    32'(mem_en),    32'd0);
        chk("reset cpu_ack",   32'(cpu_ack),   32'd0);
        chk("reset pix_valid", 32'(pix_valid), 32'd0);
        chk("reset pix_data",  32'(pix_data),  32'd0);
        chk("reset underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Prefill after reset: addresses 0..15 on cycles 0..15, then idle.
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(negedge clk);
            rst = 1'b0;
            #1;
            chk($sformatf("prefill c%0d mem_en", c), 32'(mem_en), (c < 16) ? 32'd1 : 32'd0);
            if (c < 16) chk($sformatf("prefill c%0d mem_addr", c), 32'(mem_addr), 32'(c));
            chk($sformatf("prefill c%0d pix_valid", c), 32'(pix_valid), (c >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("prefill c%0d pix_data", c), 32'(pix_data), 32'd0);
        end

        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            frame_start = vecs[i].fs;
            pix_pop     = vecs[i].pop;
            cpu_req     = vecs[i].req;
            cpu_we      = vecs[i].we;
            cpu_addr    = vecs[i].addr;
            cpu_wdata   = vecs[i].wd;
            #1;
            chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(vecs[i].en));
            if (vecs[i].en) begin
                chk($sformatf("row%0d mem_we", i),   32'(mem_we),   32'(vecs[i].mwe));
                chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
                if (vecs[i].mwe)
                    chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwd));
            end
            chk($sformatf("row%0d cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].ack));
            if (vecs[i].ack)
                chk($sformatf("row%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].rdata));
            chk($sformatf("row%0d pix_valid", i), 32'(pix_valid), 32'(vecs[i].pv));
            chk($sformatf("row%0d pix_data", i),  32'(pix_data),  32'(vecs[i].pd));
            chk($sformatf("row%0d underflow", i), 32'(underflow), 32'(vecs[i].uf));
        end

        @(negedge clk);
        frame_start = 1'b0; pix_pop = 1'b0; cpu_req = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
